// File: rtl/bram_portb_arbiter.sv
// Shares BRAM port B between the display fetch (hard priority) and an update requester.
// Optional build macro ARB_STATS_EN adds update-grant and conflict counters.
module bram_portb_arbiter #(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned STARVE_LIMIT = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_en,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_rvalid,
   input  logic              upd_req,
   input  logic              upd_we,
   input  logic [ADDR_W-1:0] upd_addr,
   input  logic [DATA_W-1:0] upd_wdata,
   output logic              upd_gnt,
   output logic [DATA_W-1:0] upd_rdata,
   output logic              upd_rvalid,
   output logic              starve,
   output logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] data_b,
   output logic              we_b,
   input  logic [DATA_W-1:0] q_b
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]       upd_grant_cnt,
   output logic [15:0]       conflict_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned TAG_D = READ_LATENCY + 1;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_DISP = 2'd1,
      TAG_UPD  = 2'd2
   } tag_e;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              we_q, we_d;
   logic              gnt_q, gnt_d;
   logic              starve_q, starve_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   tag_e              tag_q [TAG_D];
   tag_e              tag_in;
   logic              grant;

   // Arbitration: display first, then a pending update not granted last cycle
   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      we_d   = 1'b0;
      gnt_d  = 1'b0;
      grant  = 1'b0;
      tag_in = TAG_NONE;
      if (disp_en) begin
         addr_d = disp_addr;
         tag_in = TAG_DISP;
      end else if (upd_req && !gnt_q) begin
         grant  = 1'b1;
         gnt_d  = 1'b1;
         addr_d = upd_addr;
         data_d = upd_wdata;
         we_d   = upd_we;
         if (!upd_we) begin
            tag_in = TAG_UPD;
         end
      end
   end

   // Wait counter: a request still held during its grant cycle is not waiting
   always_comb begin
      cnt_d = '0;
      if (upd_req && !grant && !gnt_q) begin
         if (cnt_q == CNT_W'(STARVE_LIMIT)) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      starve_d = starve_q || (cnt_d == CNT_W'(STARVE_LIMIT));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q   <= '0;
         data_q   <= '0;
         we_q     <= 1'b0;
         gnt_q    <= 1'b0;
         starve_q <= 1'b0;
         cnt_q    <= '0;
         for (int unsigned i = 0; i < TAG_D; i++) begin
            tag_q[i] <= TAG_NONE;
         end
      end else begin
         addr_q   <= addr_d;
         data_q   <= data_d;
         we_q     <= we_d;
         gnt_q    <= gnt_d;
         starve_q <= starve_d;
         cnt_q    <= cnt_d;
         tag_q[0] <= tag_in;
         for (int unsigned i = 1; i < TAG_D; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   // Last tag stage lines up with q_b for the address it was pushed with
   assign disp_rvalid = (tag_q[READ_LATENCY] == TAG_DISP);
   assign upd_rvalid  = (tag_q[READ_LATENCY] == TAG_UPD);
   assign disp_rdata  = q_b;
   assign upd_rdata   = q_b;
   assign addr_b      = addr_q;
   assign data_b      = data_q;
   assign we_b        = we_q;
   assign upd_gnt     = gnt_q;
   assign starve      = starve_q;

`ifdef ARB_STATS_EN
   logic [15:0] gcnt_q, gcnt_d;
   logic [15:0] ccnt_q, ccnt_d;

   always_comb begin
      gcnt_d = gcnt_q;
      ccnt_d = ccnt_q;
      if (grant && (gcnt_q != 16'hFFFF)) begin
         gcnt_d = gcnt_q + 16'd1;
      end
      if (disp_en && upd_req && (ccnt_q != 16'hFFFF)) begin
         ccnt_d = ccnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gcnt_q <= '0;
         ccnt_q <= '0;
      end else begin
         gcnt_q <= gcnt_d;
         ccnt_q <= ccnt_d;
      end
   end

   assign upd_grant_cnt = gcnt_q;
   assign conflict_cnt  = ccnt_q;
`endif

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Scoreboarded bench for bram_portb_arbiter with a behavioural BRAM and reference model.
module tb_bram_portb_arbiter;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned RL     = 1;
   localparam int unsigned LIMIT  = 8;

   logic              clk = 1'b0;
   logic              reset, disp_en, upd_req, upd_we;
   logic [ADDR_W-1:0] disp_addr, upd_addr;
   logic [DATA_W-1:0] upd_wdata;
   logic [DATA_W-1:0] disp_rdata, upd_rdata, data_b, q_b;
   logic              disp_rvalid, upd_gnt, upd_rvalid, starve, we_b;
   logic [ADDR_W-1:0] addr_b;
`ifdef ARB_STATS_EN
   logic [15:0]       upd_grant_cnt, conflict_cnt;
`endif

   always #5 clk = ~clk;

   bram_portb_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .reset(reset),
      .disp_en(disp_en), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
      .upd_req(upd_req), .upd_we(upd_we), .upd_addr(upd_addr), .upd_wdata(upd_wdata),
      .upd_gnt(upd_gnt), .upd_rdata(upd_rdata), .upd_rvalid(upd_rvalid), .starve(starve),
      .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
`ifdef ARB_STATS_EN
      , .upd_grant_cnt(upd_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
   );

   function automatic logic [DATA_W-1:0] init_word(input int unsigned a);
      if (a == 5) return 16'hBEEF;
      return 16'(a * 257) ^ 16'h5A5A;
   endfunction

   // Behavioural BRAM: synchronous read with RL output stages
   logic [DATA_W-1:0] mem [1 << ADDR_W];
   logic [DATA_W-1:0] qpipe [RL];
   bit                mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else if (we_b) begin
         mem[addr_b] <= data_b;
      end
      qpipe[0] <= mem[addr_b];
      for (int i = 1; i < RL; i++) qpipe[i] <= qpipe[i-1];
   end
   assign q_b = qpipe[RL-1];

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic              is_disp;
      logic [DATA_W-1:0] data;
      logic [31:0]       due;
   } exp_t;
   exp_t sb[$];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every rvalid must match the oldest expected read, on time
   exp_t mon_e;
   always @(negedge clk) begin
      if (disp_rvalid === 1'b1 || upd_rvalid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_rvalid", 32'({disp_rvalid, upd_rvalid}), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("rvalid_route", 32'({disp_rvalid, upd_rvalid}), mon_e.is_disp ? 32'd2 : 32'd1);
            chk("rdata", mon_e.is_disp ? 32'(disp_rdata) : 32'(upd_rdata), 32'(mon_e.data));
            chk("rvalid_cycle", cyc, mon_e.due);
         end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
         mon_e = sb.pop_front();
         chk("missing_rvalid", 32'd0, 32'(mon_e.due));
      end
   end

   // Reference model state
   logic [DATA_W-1:0] smem [1 << ADDR_W];
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   logic              m_we, m_gnt, m_starve;
   int unsigned       m_cnt;
`ifdef ARB_STATS_EN
   logic [15:0]       m_gcnt, m_ccnt;
`endif

   // Predict the coming edge from current inputs, clock it, check registered outputs
   task automatic step();
      exp_t e;
      logic grant;
      if (reset) begin
         m_addr = '0; m_data = '0; m_we = 1'b0; m_gnt = 1'b0; m_starve = 1'b0; m_cnt = 0;
         sb.delete();
`ifdef ARB_STATS_EN
         m_gcnt = '0; m_ccnt = '0;
`endif
      end else begin
         grant = !disp_en && upd_req && !m_gnt;
`ifdef ARB_STATS_EN
         if (grant && m_gcnt != 16'hFFFF) m_gcnt = m_gcnt + 16'd1;
         if (disp_en && upd_req && m_ccnt != 16'hFFFF) m_ccnt = m_ccnt + 16'd1;
`endif
         if (upd_req && !grant && !m_gnt) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : m_cnt;
         else m_cnt = 0;
         if (m_cnt == LIMIT) m_starve = 1'b1;
         if (disp_en) begin
            m_addr = disp_addr; m_we = 1'b0;
            e.is_disp = 1'b1; e.data = smem[disp_addr]; e.due = cyc + 1 + RL;
            sb.push_back(e);
         end else if (grant) begin
            m_addr = upd_addr; m_data = upd_wdata; m_we = upd_we;
            if (upd_we) begin
               smem[upd_addr] = upd_wdata;
            end else begin
               e.is_disp = 1'b0; e.data = smem[upd_addr]; e.due = cyc + 1 + RL;
               sb.push_back(e);
            end
         end else begin
            m_we = 1'b0;
         end
         m_gnt = grant;
      end
      @(posedge clk); #1;
      chk("upd_gnt", 32'(upd_gnt), 32'(m_gnt));
      chk("we_b", 32'(we_b), 32'(m_we));
      chk("addr_b", 32'(addr_b), 32'(m_addr));
      chk("data_b", 32'(data_b), 32'(m_data));
      chk("starve", 32'(starve), 32'(m_starve));
`ifdef ARB_STATS_EN
      chk("upd_grant_cnt", 32'(upd_grant_cnt), 32'(m_gcnt));
      chk("conflict_cnt", 32'(conflict_cnt), 32'(m_ccnt));
`endif
      @(negedge clk); #1;
   endtask

   task automatic set_in(input logic de, input int unsigned da, input logic ur, input logic uw,
                         input int unsigned ua, input int unsigned ud);
      disp_en = de; disp_addr = ADDR_W'(da);
      upd_req = ur; upd_we = uw; upd_addr = ADDR_W'(ua); upd_wdata = DATA_W'(ud);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         set_in(1'b0, 0, 1'b0, 1'b0, 0, 0);
         step();
      end
   endtask

   initial begin
      logic dmode;
      for (int i = 0; i < (1 << ADDR_W); i++) smem[i] = init_word(i);
      reset = 1'b1;
      set_in(1'b0, 0, 1'b0, 1'b0, 0, 0);
      step(); step();
      reset = 1'b0;

      // Display read of 0x005
      set_in(1'b1, 5, 1'b0, 1'b0, 0, 0); step();
      idle(3);

      // Update write 0x010 then update read back
      set_in(1'b0, 0, 1'b1, 1'b1, 16'h010, 16'h1234); step();
      idle(3);
      set_in(1'b0, 0, 1'b1, 1'b0, 16'h010, 0); step();
      idle(3);

      // Display held for 20 cycles while an update read waits (starves)
      for (int unsigned i = 0; i < 20; i++) begin
         set_in(1'b1, 40 + i, 1'b1, 1'b0, 16'h020, 0); step();
      end
      set_in(1'b0, 0, 1'b1, 1'b0, 16'h020, 0); step();
      idle(3);

      // Interleaved display and update reads
      set_in(1'b1, 5, 1'b1, 1'b0, 16'h010, 0); step();
      set_in(1'b0, 0, 1'b1, 1'b0, 16'h010, 0); step();
      set_in(1'b1, 7, 1'b1, 1'b0, 16'h003, 0); step();
      set_in(1'b0, 0, 1'b1, 1'b0, 16'h003, 0); step();
      set_in(1'b1, 16'h010, 1'b0, 1'b0, 0, 0); step();
      idle(3);

      // Reset clears starve
      reset = 1'b1; step(); reset = 1'b0;
      idle(2);

      // Update read followed immediately by reset: the read is dropped
      set_in(1'b0, 0, 1'b1, 1'b0, 16'h010, 0); step();
      reset = 1'b1; set_in(1'b0, 0, 1'b0, 1'b0, 0, 0); step(); reset = 1'b0;
      idle(4);

      // Randomised traffic with display bursts and occasional reset
      dmode = 1'b0;
      for (int unsigned n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 15) == 0) dmode = ~dmode;
         disp_en   = dmode ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
         disp_addr = ADDR_W'($urandom_range(0, 31));
         if (!upd_req || m_gnt) begin
            upd_req   = ($urandom_range(0, 1) == 1);
            upd_we    = ($urandom_range(0, 1) == 1);
            upd_addr  = ADDR_W'($urandom_range(0, 31));
            upd_wdata = DATA_W'($urandom);
         end
         step();
      end
      reset = 1'b0;
      idle(6);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
